// File: rtl/bpmc_mux_arb.sv
// Two-requester frame arbiter and sequencer for the BPMC bit-serial mux pipeline.
// Define BPMC_ARB_RR_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
`timescale 1ns/1ps

module bpmc_mux_arb #(
    parameter int FRAME_LEN = 16,
    parameter int PIPE_LAT  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic dat0,
    input  logic dat1,
    output logic gnt0,
    output logic gnt1,
    output logic sel_out,
    output logic din_out,
    output logic out_valid,
    output logic out_owner,
    output logic frame_done,
    output logic busy
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FW = $clog2(PIPE_LAT + 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] beat;
    logic [FW-1:0] fcnt;
    logic          owner;
    logic          win;
    logic          any_req;
    logic          last_out;
    logic          owner_out;
    logic [PIPE_LAT-1:0] pv;
    logic [PIPE_LAT-1:0] po;
    logic [PIPE_LAT-1:0] pl;

    assign any_req = req0 | req1;

`ifdef BPMC_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        win = req1 & ~req0;
        if (req0 && req1) win = rr_ptr;
    end

    // Pointer always moves to the requester that did not just win.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= 1'b0;
        else if (state == IDLE && any_req) rr_ptr <= ~win;
    end
`else
    assign win = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = STREAM;
            STREAM:  if (beat == BEAT_LAST) state_nxt = FLUSH;
            FLUSH:   if (fcnt == FLUSH_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        busy = (state != IDLE);
        if (state == STREAM) begin
            gnt0 = ~owner;
            gnt1 = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            fcnt      <= '0;
            owner     <= 1'b0;
            sel_out   <= 1'b0;
            din_out   <= 1'b0;
            last_out  <= 1'b0;
            owner_out <= 1'b0;
            pv        <= '0;
            po        <= '0;
            pl        <= '0;
        end else begin
            beat <= (state == STREAM) ? beat + 1'b1 : '0;
            fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
            if (state == IDLE && any_req) owner <= win;
            sel_out   <= (state == STREAM);
            din_out   <= (state == STREAM) & (owner ? dat1 : dat0);
            last_out  <= (state == STREAM) & (beat == BEAT_LAST);
            owner_out <= (state == STREAM) & owner;
            // Tracking line mirrors the mux pipeline depth.
            pv[0] <= sel_out;
            po[0] <= owner_out;
            pl[0] <= last_out;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
                pl[i] <= pl[i-1];
            end
        end
    end

    assign out_valid  = pv[PIPE_LAT-1];
    assign out_owner  = po[PIPE_LAT-1];
    assign frame_done = pv[PIPE_LAT-1] & pl[PIPE_LAT-1];

endmodule

// File: doc/bpmc_mux_arb.md
# bpmc_mux_arb

Two-requester arbiter and sequencer for the BPMC 2-to-1 bit-serial mux pipeline. Grants the shared mux to one requester for a fixed-length frame, drives the pipeline's select and data inputs, and tracks the pipeline latency so downstream logic knows which output bits are valid and who owns them. It sits between the waveform bit-stream sources and the BPMC mux/register chain in the function-generator datapath.

## Interface

- FRAME_LEN, 16: bits per granted frame; legal range 2..256.
- PIPE_LAT, 4: cycles from `sel_out`/`din_out` to the mux output (three pipeline regs plus the output reg); legal range 1..15.

- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  request lines, held high while a frame is wanted.
- dat0, dat1  input  1 each  serial data; sampled only while the matching `gnt` is high.
- gnt0, gnt1  output  1 each  grant; high for exactly FRAME_LEN consecutive cycles per frame.
- sel_out  output  1  pipeline select, registered; high while a frame bit is being issued.
- din_out  output  1  pipeline data bit, registered.
- out_valid  output  1  high when the mux output carries a frame bit.
- out_owner  output  1  owner of the bit under `out_valid` (0 = req0, 1 = req1).
- frame_done  output  1  one-cycle pulse on the last valid output bit of a frame.
- busy  output  1  high in any state other than IDLE.

## Operation

- States are IDLE, STREAM and FLUSH. The encoding is free.
- IDLE: requests are evaluated every cycle.
  - If any req is high, latch the owner, enter STREAM, clear the beat counter and raise the owner's gnt.
  - If both reqs are high, the round-robin pointer decides (see Configuration). The winner gets the grant and the pointer moves to the other requester.
- STREAM:
  - Each cycle, register `sel_out`=1 and `din_out`=dat of the owner. Increment the beat counter (width clog2(FRAME_LEN)).
  - On beat FRAME_LEN-1, drop gnt and enter FLUSH.
  - A req deassert mid-frame is ignored; the frame always completes with whatever dat is presented.
- FLUSH:
  - Hold `sel_out`=0 and `din_out`=0 for PIPE_LAT cycles, then enter IDLE.
  - Requests are not evaluated in FLUSH. This guarantees no two frames share the pipeline.
- Valid tracking: a PIPE_LAT-deep shift register carries {sel_out, owner}. Its tail drives `out_valid` and `out_owner`.
- `frame_done` is high when the tail is valid, the tail-1 entry is not valid (or PIPE_LAT==1 and the frame has ended), and the frame's last bit is at the tail. Implement this with a delayed last-beat flag in the same shift register.
- gnt0 and gnt1 are never high together.

## Timing

- Reset values: gnt0=gnt1=0, sel_out=0, din_out=0, out_valid=0, out_owner=0, frame_done=0, busy=0. State is IDLE, the round-robin pointer points to req0, and the shift register is cleared.
- Reset asserted mid-frame aborts immediately. Partial-frame bits already in the tracking register are discarded: `out_valid` is 0 on the cycle after reset.
- For req sampled high in IDLE at edge t:
  - gnt is high during cycles t+1..t+FRAME_LEN.
  - `sel_out` is high during t+2..t+FRAME_LEN+1.
  - `out_valid` is high during t+2+PIPE_LAT..t+FRAME_LEN+1+PIPE_LAT.
- Minimum request-to-request spacing for one continuously requesting source is FRAME_LEN+PIPE_LAT+1 cycles.
- `busy` is high from t+1 until the last FLUSH cycle inclusive.

## Configuration

- `BPMC_ARB_RR_EN` defined: round-robin. The pointer toggles after every grant, so when both requesters are continuously requesting the grants alternate 0,1,0,1.
- Not defined: fixed priority, req0 always wins ties, and the pointer logic is removed. All other behaviour is identical.

## Test plan

- Reset, then req0 held for one frame, FRAME_LEN=16, PIPE_LAT=4, dat0 pattern 0xA5C3 MSB-first. Required: gnt0 high for 16 cycles, out_valid high for 16 cycles starting 6 cycles after the request edge, `din_out` reproduces 0xA5C3, frame_done pulses once on the 16th valid bit, out_owner=0.
- req0 and req1 both held continuously with `BPMC_ARB_RR_EN` defined. Required: frames are granted 0,1,0,1, each grant is 16 cycles, each FLUSH is 4 cycles, and gnt0 and gnt1 never overlap.
- Same stimulus without the macro. Required: only gnt0 ever asserts and req1 starves.
- req1 deasserted on beat 5 of its frame. Required: gnt1 still lasts 16 cycles and exactly 16 valid bits appear with out_owner=1.
- Reset pulsed for one cycle on beat 8 of a frame. Required: the next cycle shows all outputs 0 and state IDLE; no further out_valid or frame_done for the aborted frame; a new req0 is granted normally.
- FRAME_LEN=2, PIPE_LAT=1, req1 pulsed for a single cycle. Required: gnt1 is high for 2 cycles, out_valid is high for 2 cycles starting 3 cycles after the request edge, and frame_done pulses on the second valid bit.
